mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 180 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM pipeline stage with a request/ready data-memory port.
// State updates on the falling edge of clk. Reset is asynchronous, active-high.
// Ports:
//   clk, reset, cu_flush               clock, reset, discard the MEM instruction
//   exmem_*                            EX/MEM payload (flags, rd, address/result, store data, load type)
//   mem_byte_w_en                      store byte enables
//   dmem_req/we/addr/wdata/be          data-memory request, held stable while BUSY
//   dmem_ready, dmem_rdata             transaction completion and read data
//   mem_stall, mem_addr_err            upstream freeze and misaligned-access flag (combinational)
//   memwb_reg_w/rd_addr/wdata          registered MEM/WB writeback payload
module mem_access_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        cu_flush,
   input  logic        exmem_mem_r,
   input  logic        exmem_mem_w,
   input  logic        exmem_reg_w,
   input  logic [4:0]  exmem_rd_addr,
   input  logic [31:0] exmem_alu_res,
   input  logic [31:0] exmem_aligned_rt_data,
   input  logic [3:0]  mem_byte_w_en,
   input  logic [2:0]  exmem_load_sel,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic        dmem_ready,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic        mem_addr_err,
   output logic        memwb_reg_w,
   output logic [4:0]  memwb_rd_addr,
   output logic [31:0] memwb_wdata
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned RD_W   = 5;
   localparam int unsigned BE_W   = 4;
   localparam int unsigned SEL_W  = 3;

   localparam logic [SEL_W-1:0] SEL_LB  = SEL_W'(1);
   localparam logic [SEL_W-1:0] SEL_LBU = SEL_W'(2);
   localparam logic [SEL_W-1:0] SEL_LH  = SEL_W'(3);
   localparam logic [SEL_W-1:0] SEL_LHU = SEL_W'(4);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t state_q, state_d;

   logic              is_mem, word_cls, half_cls, access;
   logic              drop_q, load_q, regw_q;
   logic [SEL_W-1:0]  lsel_q;
   logic [1:0]        lane_q;
   logic [RD_W-1:0]   rd_q;
   logic [DATA_W-1:0] rdata_q, ld_ext;
   logic [7:0]        ld_byte;
   logic [15:0]       ld_half;

   // Alignment check and access qualification
   always_comb begin
      is_mem   = exmem_mem_r | exmem_mem_w;
      half_cls = (exmem_load_sel == SEL_LH) || (exmem_load_sel == SEL_LHU);
      word_cls = !half_cls && (exmem_load_sel != SEL_LB) && (exmem_load_sel != SEL_LBU);
      mem_addr_err = !reset && is_mem &&
                     ((word_cls && (exmem_alu_res[1:0] != 2'b00)) ||
                      (half_cls && exmem_alu_res[0]));
      access = is_mem && !cu_flush && !mem_addr_err;
   end

   // State register
   always_ff @(negedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next state and stall
   always_comb begin
      state_d   = state_q;
      mem_stall = 1'b0;
      case (state_q)
         S_IDLE: begin
            mem_stall = access;
            if (access) state_d = S_BUSY;
         end
         S_BUSY: begin
            mem_stall = 1'b1;
            if (dmem_ready) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Load lane select and extension from the captured read word
   always_comb begin
      ld_byte = 8'h00;
      ld_ext  = rdata_q;
      case (lane_q)
         2'd0:    ld_byte = rdata_q[7:0];
         2'd1:    ld_byte = rdata_q[15:8];
         2'd2:    ld_byte = rdata_q[23:16];
         default: ld_byte = rdata_q[31:24];
      endcase
      ld_half = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
      case (lsel_q)
         SEL_LB:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
         SEL_LBU: ld_ext = {24'h000000, ld_byte};
         SEL_LH:  ld_ext = {{16{ld_half[15]}}, ld_half};
         SEL_LHU: ld_ext = {16'h0000, ld_half};
         default: ld_ext = rdata_q;
      endcase
   end

   // Bus request registers, transaction context and MEM/WB outputs
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         dmem_req      <= 1'b0;
         dmem_we       <= 1'b0;
         dmem_addr     <= '0;
         dmem_wdata    <= '0;
         dmem_be       <= '0;
         drop_q        <= 1'b0;
         load_q        <= 1'b0;
         regw_q        <= 1'b0;
         lsel_q        <= '0;
         lane_q        <= '0;
         rd_q          <= '0;
         rdata_q       <= '0;
         memwb_reg_w   <= 1'b0;
         memwb_rd_addr <= '0;
         memwb_wdata   <= '0;
      end else begin
         case (state_q)
            S_IDLE: if (access) begin
               dmem_req   <= 1'b1;
               dmem_we    <= exmem_mem_w;
               dmem_addr  <= {exmem_alu_res[31:2], 2'b00};
               dmem_wdata <= exmem_aligned_rt_data;
               dmem_be    <= exmem_mem_w ? mem_byte_w_en : BE_W'(4'hF);
               load_q     <= exmem_mem_r & !exmem_mem_w;
               regw_q     <= exmem_reg_w;
               lsel_q     <= exmem_load_sel;
               lane_q     <= exmem_alu_res[1:0];
               rd_q       <= exmem_rd_addr;
               drop_q     <= 1'b0;
            end
            S_BUSY: begin
               // A flush here cannot abort the bus cycle; remember to drop the writeback.
               if (cu_flush) drop_q <= 1'b1;
               if (dmem_ready) begin
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
                  dmem_be  <= '0;
                  rdata_q  <= dmem_rdata;
               end
            end
            S_DONE:  drop_q <= 1'b0;
            default: drop_q <= 1'b0;
         endcase

         if (!mem_stall) begin
            if (state_q == S_DONE) begin
               memwb_reg_w   <= regw_q & load_q & !drop_q;
               memwb_rd_addr <= rd_q;
               memwb_wdata   <= load_q ? ld_ext : exmem_alu_res;
            end else if (cu_flush) begin
               memwb_reg_w   <= 1'b0;
               memwb_rd_addr <= '0;
               memwb_wdata   <= '0;
            end else begin
               memwb_reg_w   <= exmem_reg_w & !mem_addr_err & !exmem_mem_w;
               memwb_rd_addr <= exmem_rd_addr;
               memwb_wdata   <= exmem_alu_res;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized
// ALU ops, loads, stores and misaligned accesses against a behavioural model.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        reset, cu_flush;
   logic        exmem_mem_r, exmem_mem_w, exmem_reg_w;
   logic [4:0]  exmem_rd_addr;
   logic [31:0] exmem_alu_res, exmem_aligned_rt_data;
   logic [3:0]  mem_byte_w_en;
   logic [2:0]  exmem_load_sel;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic [3:0]  dmem_be;
   logic        dmem_ready;
   logic [31:0] dmem_rdata;
   logic        mem_stall, mem_addr_err, memwb_reg_w;
   logic [4:0]  memwb_rd_addr;
   logic [31:0] memwb_wdata;

   int n_checks = 0;
   int n_pass   = 0;

   mem_access_unit dut (
      .clk(clk), .reset(reset), .cu_flush(cu_flush),
      .exmem_mem_r(exmem_mem_r), .exmem_mem_w(exmem_mem_w), .exmem_reg_w(exmem_reg_w),
      .exmem_rd_addr(exmem_rd_addr), .exmem_alu_res(exmem_alu_res),
      .exmem_aligned_rt_data(exmem_aligned_rt_data), .mem_byte_w_en(mem_byte_w_en),
      .exmem_load_sel(exmem_load_sel),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
      .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
      .mem_stall(mem_stall), .mem_addr_err(mem_addr_err),
      .memwb_reg_w(memwb_reg_w), .memwb_rd_addr(memwb_rd_addr), .memwb_wdata(memwb_wdata)
   );

   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   function automatic int acc_width(input logic [2:0] sel);
      if (sel == 3'd1 || sel == 3'd2) return 1;
      if (sel == 3'd3 || sel == 3'd4) return 2;
      return 4;
   endfunction

   function automatic logic exp_err(input logic r, input logic w, input logic [2:0] sel,
                                    input logic [31:0] a);
      if (!(r | w)) return 1'b0;
      return (a % acc_width(sel)) != 0;
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] sel, input logic [31:0] a,
                                            input logic [31:0] rd);
      int     w, off;
      longint v, base;
      w    = acc_width(sel);
      off  = (int'(a % 4) / w) * w;
      base = longint'(1) << (8 * w);
      v    = longint'(rd >> (8 * off)) % base;
      if ((sel == 3'd1 || sel == 3'd3) && v >= base / 2) v = v - base;
      return 32'(v);
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cu_flush = 0; exmem_mem_r = 0; exmem_mem_w = 0; exmem_reg_w = 0;
      exmem_rd_addr = 0; exmem_alu_res = 0; exmem_aligned_rt_data = 0;
      mem_byte_w_en = 0; exmem_load_sel = 0; dmem_ready = 0; dmem_rdata = 0;
   endtask

   // One complete load/store: IDLE edge, n BUSY edges (ready on the n-th), DONE edge.
   task automatic run_mem_access(input bit st, input logic [2:0] sel, input logic [31:0] a,
                                 input logic [31:0] rt, input logic [3:0] be,
                                 input logic [31:0] rdat, input int n, input int flush_at,
                                 input logic [4:0] rd, input logic rw, input string tag);
      logic        p_rw, e_rw;
      logic [4:0]  p_rd;
      logic [31:0] p_wd, e_wd;
      int          stalls;
      p_rw = memwb_reg_w; p_rd = memwb_rd_addr; p_wd = memwb_wdata;
      exmem_mem_r = !st; exmem_mem_w = st; exmem_reg_w = rw; exmem_rd_addr = rd;
      exmem_alu_res = a; exmem_aligned_rt_data = rt; mem_byte_w_en = be;
      exmem_load_sel = sel; cu_flush = 0; dmem_ready = 0;
      #1;
      n_checks++; if (mem_addr_err !== 1'b0) $display("FAIL %s err: got %0b want 0", tag, mem_addr_err); else n_pass++;
      n_checks++; if (dmem_req !== 1'b0) $display("FAIL %s req_idle: got %0b want 0", tag, dmem_req); else n_pass++;
      stalls = mem_stall ? 1 : 0;
      tick();
      for (int k = 1; k <= n; k++) begin
         n_checks++; if (dmem_req !== 1'b1) $display("FAIL %s req_busy%0d: got %0b want 1", tag, k, dmem_req); else n_pass++;
         n_checks++; if (dmem_addr !== a - (a % 4)) $display("FAIL %s addr: got %h want %h", tag, dmem_addr, a - (a % 4)); else n_pass++;
         n_checks++; if (dmem_we !== st) $display("FAIL %s we: got %0b want %0b", tag, dmem_we, st); else n_pass++;
         n_checks++; if (dmem_be !== (st ? be : 4'hF)) $display("FAIL %s be: got %h want %h", tag, dmem_be, st ? be : 4'hF); else n_pass++;
         if (st) begin
            n_checks++; if (dmem_wdata !== rt) $display("FAIL %s wdata: got %h want %h", tag, dmem_wdata, rt); else n_pass++;
         end
         if (k == flush_at) cu_flush = 1;
         if (k == n) begin dmem_ready = 1; dmem_rdata = rdat; end
         #1;
         if (mem_stall) stalls++;
         tick();
      end
      cu_flush = 0; dmem_ready = 0; dmem_rdata = $urandom;
      #1;
      n_checks++; if (dmem_req !== 1'b0) $display("FAIL %s req_done: got %0b want 0", tag, dmem_req); else n_pass++;
      n_checks++; if (dmem_we !== 1'b0) $display("FAIL %s we_done: got %0b want 0", tag, dmem_we); else n_pass++;
      n_checks++; if (mem_stall !== 1'b0) $display("FAIL %s stall_done: got %0b want 0", tag, mem_stall); else n_pass++;
      n_checks++; if (stalls !== n + 1) $display("FAIL %s stall_edges: got %0d want %0d", tag, stalls, n + 1); else n_pass++;
      n_checks++; if ({memwb_reg_w, memwb_rd_addr, memwb_wdata} !== {p_rw, p_rd, p_wd})
         $display("FAIL %s memwb_hold: got %h want %h", tag, {memwb_reg_w, memwb_rd_addr, memwb_wdata}, {p_rw, p_rd, p_wd}); else n_pass++;
      e_rw = rw & !st & (flush_at == 0);
      e_wd = st ? a : exp_load(sel, a, rdat);
      tick();
      idle_inputs();
      n_checks++; if (memwb_reg_w !== e_rw) $display("FAIL %s regw: got %0b want %0b", tag, memwb_reg_w, e_rw); else n_pass++;
      n_checks++; if (memwb_rd_addr !== rd) $display("FAIL %s rd: got %0d want %0d", tag, memwb_rd_addr, rd); else n_pass++;
      n_checks++; if (memwb_wdata !== e_wd) $display("FAIL %s wbdata: got %h want %h", tag, memwb_wdata, e_wd); else n_pass++;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset = 1; idle_inputs();
      #2;
      n_checks++; if ({dmem_req, dmem_we, dmem_be, mem_addr_err, mem_stall} !== 8'h00)
         $display("FAIL reset_ctrl: got %h want 00", {dmem_req, dmem_we, dmem_be, mem_addr_err, mem_stall}); else n_pass++;
      n_checks++; if ({dmem_addr, dmem_wdata} !== 64'h0) $display("FAIL reset_bus: got %h want 0", {dmem_addr, dmem_wdata}); else n_pass++;
      n_checks++; if ({memwb_reg_w, memwb_rd_addr, memwb_wdata} !== 38'h0)
         $display("FAIL reset_memwb: got %h want 0", {memwb_reg_w, memwb_rd_addr, memwb_wdata}); else n_pass++;
      exmem_mem_r = 1; exmem_alu_res = 32'h3; exmem_reg_w = 1; exmem_rd_addr = 5'd9;
      tick(); tick();
      n_checks++; if ({dmem_req, mem_addr_err, memwb_reg_w} !== 3'b000)
         $display("FAIL reset_held: got %b want 000", {dmem_req, mem_addr_err, memwb_reg_w}); else n_pass++;
      idle_inputs();
      #1 reset = 0;
   endtask

   task automatic test_alu();
      for (int i = 0; i < 8; i++) begin
         logic        rw;
         logic [4:0]  rd;
         logic [31:0] res;
         rw = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
         rd = (i == 0) ? 5'd5 : 5'($urandom);
         res = (i == 0) ? 32'h1234 : $urandom;
         exmem_reg_w = rw; exmem_rd_addr = rd; exmem_alu_res = res;
         exmem_mem_r = 0; exmem_mem_w = 0; exmem_load_sel = 3'($urandom);
         #1;
         n_checks++; if (mem_stall !== 1'b0) $display("FAIL alu_stall%0d: got %0b want 0", i, mem_stall); else n_pass++;
         tick();
         n_checks++; if ({memwb_reg_w, memwb_rd_addr, memwb_wdata} !== {rw, rd, res})
            $display("FAIL alu%0d memwb: got %h want %h", i, {memwb_reg_w, memwb_rd_addr, memwb_wdata}, {rw, rd, res}); else n_pass++;
      end
      idle_inputs();
   endtask

   task automatic test_directed();
      run_mem_access(0, 3'd1, 32'h103, 32'h0, 4'h0, 32'h80FF_FF7F, 2, 0, 5'd7, 1, "lb_103");
      run_mem_access(0, 3'd4, 32'h102, 32'h0, 4'h0, 32'hBEEF_1234, 1, 0, 5'd8, 1, "lhu_102");
      run_mem_access(1, 3'd0, 32'h200, 32'hCAFE_BABE, 4'hF, 32'h0, 1, 0, 5'd0, 0, "sw_200");
      run_mem_access(0, 3'd0, 32'h40, 32'h0, 4'h0, 32'h1111_2222, 3, 1, 5'd3, 1, "flush_busy");
      run_mem_access(0, 3'd0, 32'h44, 32'h0, 4'h0, 32'h3333_4444, 2, 2, 5'd4, 1, "flush_ready");
   endtask

   task automatic test_misaligned();
      for (int i = 0; i < 8; i++) begin
         logic [2:0]  sel;
         logic [31:0] a, res_prev;
         logic        st, e;
         st  = (i == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         sel = (i == 0) ? 3'd3 : (st ? 3'd0 : 3'($urandom_range(0, 7)));
         a   = (i == 0) ? 32'h103 : $urandom | 32'h1;
         e   = exp_err(!st, st, sel, a);
         res_prev = a;
         exmem_mem_r = !st; exmem_mem_w = st; exmem_reg_w = 1; exmem_rd_addr = 5'd12;
         exmem_alu_res = a; exmem_load_sel = sel;
         #1;
         n_checks++; if (mem_addr_err !== e) $display("FAIL mis%0d err: got %0b want %0b", i, mem_addr_err, e); else n_pass++;
         if (e) begin
            n_checks++; if ({mem_stall, dmem_req} !== 2'b00) $display("FAIL mis%0d stall_req: got %b want 00", i, {mem_stall, dmem_req}); else n_pass++;
            tick();
            n_checks++; if ({dmem_req, memwb_reg_w} !== 2'b00) $display("FAIL mis%0d req_regw: got %b want 00", i, {dmem_req, memwb_reg_w}); else n_pass++;
            n_checks++; if (memwb_wdata !== res_prev) $display("FAIL mis%0d wbdata: got %h want %h", i, memwb_wdata, res_prev); else n_pass++;
         end else begin
            idle_inputs();
            run_mem_access(st, sel, a, $urandom, 4'($urandom_range(1, 15)), $urandom,
                           $urandom_range(1, 3), 0, 5'd12, 1, "mis_ok");
         end
         idle_inputs();
      end
   endtask

   task automatic test_flush_idle();
      exmem_mem_r = 1; exmem_alu_res = 32'h80; exmem_reg_w = 1; exmem_rd_addr = 5'd6; cu_flush = 1;
      #1;
      n_checks++; if (mem_stall !== 1'b0) $display("FAIL flush_idle_stall: got %0b want 0", mem_stall); else n_pass++;
      tick();
      n_checks++; if ({dmem_req, memwb_reg_w, memwb_rd_addr, memwb_wdata} !== 39'h0)
         $display("FAIL flush_idle_memwb: got %h want 0", {dmem_req, memwb_reg_w, memwb_rd_addr, memwb_wdata}); else n_pass++;
      idle_inputs();
   endtask

   task automatic test_random_mem();
      for (int i = 0; i < 12; i++) begin
         logic [2:0]  sel;
         logic [31:0] a;
         logic        st;
         st  = 1'($urandom_range(0, 2) == 0);
         sel = st ? 3'd0 : 3'($urandom_range(0, 7));
         a   = $urandom;
         a   = a - (a % acc_width(sel));
         run_mem_access(st, sel, a, $urandom, 4'($urandom_range(1, 15)), $urandom,
                        $urandom_range(1, 4), 0, 5'($urandom), 1'($urandom_range(0, 1)), "rand_mem");
      end
   endtask

   task automatic test_back_to_back();
      exmem_reg_w = 1; exmem_rd_addr = 5'd1; exmem_alu_res = 32'hA5A5_0001;
      tick();
      n_checks++; if (memwb_wdata !== 32'hA5A5_0001) $display("FAIL b2b_alu1: got %h want a5a50001", memwb_wdata); else n_pass++;
      run_mem_access(0, 3'd2, 32'h301, 32'h0, 4'h0, 32'h0000_9C00, 1, 0, 5'd2, 1, "b2b_lbu");
      exmem_reg_w = 1; exmem_rd_addr = 5'd3; exmem_alu_res = 32'h0BAD_F00D;
      tick();
      n_checks++; if ({memwb_reg_w, memwb_rd_addr, memwb_wdata} !== {1'b1, 5'd3, 32'h0BAD_F00D})
         $display("FAIL b2b_alu2: got %h want %h", {memwb_reg_w, memwb_rd_addr, memwb_wdata}, {1'b1, 5'd3, 32'h0BAD_F00D}); else n_pass++;
      idle_inputs();
      run_mem_access(1, 3'd0, 32'h404, 32'h1234_5678, 4'h3, 32'h0, 2, 0, 5'd0, 0, "b2b_sh");
   endtask

   task automatic test_reset_busy();
      exmem_reg_w = 1; exmem_rd_addr = 5'd10; exmem_alu_res = 32'h5555_AAAA;
      tick();
      exmem_mem_r = 1; exmem_reg_w = 1; exmem_rd_addr = 5'd11; exmem_alu_res = 32'h500; exmem_load_sel = 0;
      tick();
      n_checks++; if (dmem_req !== 1'b1) $display("FAIL rstbusy_req_before: got %0b want 1", dmem_req); else n_pass++;
      #1 reset = 1;
      #1;
      n_checks++; if (dmem_req !== 1'b0) $display("FAIL rstbusy_req: got %0b want 0", dmem_req); else n_pass++;
      n_checks++; if ({memwb_reg_w, memwb_rd_addr, memwb_wdata, dmem_addr} !== 70'h0)
         $display("FAIL rstbusy_memwb: got %h want 0", {memwb_reg_w, memwb_rd_addr, memwb_wdata, dmem_addr}); else n_pass++;
      idle_inputs();
      #1;
      n_checks++; if (mem_stall !== 1'b0) $display("FAIL rstbusy_stall: got %0b want 0", mem_stall); else n_pass++;
      reset = 0;
      tick();
      run_mem_access(0, 3'd3, 32'h602, 32'h0, 4'h0, 32'h8001_0002, 2, 0, 5'd13, 1, "after_rst_lh");
   endtask

   initial begin
      test_reset();
      test_alu();
      test_directed();
      test_misaligned();
      test_flush_idle();
      test_random_mem();
      test_back_to_back();
      test_reset_busy();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
